// File: rtl/dsp_in_registered_acc.sv
// dsp_in_registered_acc
// Input-registered multiply/add slice with a counted accumulator.
// Operands are captured in stage A on a valid/ready handshake. Each stage-A
// beat is folded into the accumulator, and every ACC_LEN beats the group
// total is loaded into a held output register that stays put until it is
// consumed.
// Optional build macro: DSP_ACC_SATURATE_EN clamps acc + r at 2^ACC_WIDTH-1
// instead of wrapping.
//
// state | meaning
// ------+---------------------------------------------------------------
// ACCUM | stage A beats are consumed and accumulated
// HOLD  | group result held on out until out_ready; stage A is not consumed
module dsp_in_registered_acc #(
    parameter int DATA_WIDTH = 4,
    parameter int ACC_LEN    = 4,
    parameter int ACC_WIDTH  = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH/2-1:0]   a,
    input  logic [DATA_WIDTH/2-1:0]   b,
    input  logic                      m,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_WIDTH-1:0]      out
);

    localparam int OPW   = DATA_WIDTH / 2;
    localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [OPW-1:0]        a_q;
    logic [OPW-1:0]        b_q;
    logic                  m_q;
    logic                  a_vld;
    logic [ACC_WIDTH-1:0]  acc;
    logic [CNT_W-1:0]      cnt;

    logic                  load;
    logic                  consume;
    logic                  last_op;

    logic [DATA_WIDTH-1:0] prod;
    logic [OPW:0]          sum_ab;
    logic [ACC_WIDTH-1:0]  r;
    logic [ACC_WIDTH-1:0]  acc_nxt;

    // Per-op result from the registered operands, zero-extended
    assign prod   = DATA_WIDTH'(a_q) * DATA_WIDTH'(b_q);
    assign sum_ab = (OPW+1)'(a_q) + (OPW+1)'(b_q);
    assign r      = m_q ? ACC_WIDTH'(prod) : ACC_WIDTH'(sum_ab);

`ifdef DSP_ACC_SATURATE_EN
    logic [ACC_WIDTH:0] acc_sum;

    // Carry out of the accumulator width means the group total overflowed
    assign acc_sum = {1'b0, acc} + {1'b0, r};
    assign acc_nxt = acc_sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : acc_sum[ACC_WIDTH-1:0];
`else
    assign acc_nxt = acc + r;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: leave ACCUM on the last op of a group, leave HOLD on out_ready
    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (last_op)   state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    // FSM outputs: handshake and stage-A consume strobes
    always_comb begin
        in_ready = !rst && ((state == ACCUM) || !a_vld);
        consume  = (state == ACCUM) && a_vld;
        load     = in_valid && in_ready;
        last_op  = consume && (cnt == CNT_LAST);
    end

    // Stage A: operand capture; a new beat may load in the same cycle the old one is consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            m_q   <= 1'b0;
            a_vld <= 1'b0;
        end else if (load) begin
            a_q   <= a;
            b_q   <= b;
            m_q   <= m;
            a_vld <= 1'b1;
        end else if (consume) begin
            a_vld <= 1'b0;
        end
    end

    // Accumulator, op counter and held result register
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else if (consume) begin
            if (cnt == CNT_LAST) begin
                out       <= acc_nxt;
                out_valid <= 1'b1;
                acc       <= '0;
                cnt       <= '0;
            end else begin
                acc <= acc_nxt;
                cnt <= cnt + 1'b1;
            end
        end else if ((state == HOLD) && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dsp_in_registered_acc.sv
// Bench for dsp_in_registered_acc: three instances (defaults, ACC_WIDTH=5,
// ACC_LEN=1) share one stimulus stream. A transaction-level scoreboard sums
// accepted beats per group and compares every consumed result; directed
// sequences check latency, bubbles, backpressure and reset.
module tb_dsp_in_registered_acc;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [1:0] a;
    logic [1:0] b;
    logic       m;
    logic       out_ready;

    logic       ir0, ov0, ir5, ov5, ir1, ov1;
    logic [5:0] out0;
    logic [4:0] out5;
    logic [5:0] out1;

    int tests = 0;
    int fails = 0;
    int stalls = 0;

`ifdef DSP_ACC_SATURATE_EN
    localparam int E5_36 = 31;
`else
    localparam int E5_36 = 4;
`endif

    dsp_in_registered_acc dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .a(a), .b(b), .m(m),
        .out_valid(ov0), .out_ready(out_ready), .out(out0)
    );

    dsp_in_registered_acc #(.ACC_WIDTH(5)) dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir5), .a(a), .b(b), .m(m),
        .out_valid(ov5), .out_ready(out_ready), .out(out5)
    );

    dsp_in_registered_acc #(.ACC_LEN(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .a(a), .b(b), .m(m),
        .out_valid(ov1), .out_ready(out_ready), .out(out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    function automatic int op_res(input logic [1:0] aa, input logic [1:0] bb, input logic mm);
        return mm ? int'(aa) * int'(bb) : int'(aa) + int'(bb);
    endfunction

    function automatic int grp_res(input int s, input int w);
        int mx;
        mx = (1 << w) - 1;
`ifdef DSP_ACC_SATURATE_EN
        return (s > mx) ? mx : s;
`else
        return s & mx;
`endif
    endfunction

    // ---------------- scoreboard ----------------
    localparam int WID [3] = '{6, 5, 6};
    localparam int LEN [3] = '{4, 4, 1};

    logic       irs  [3];
    logic       ovs  [3];
    logic [5:0] outs [3];
    assign irs[0] = ir0;  assign ovs[0] = ov0;  assign outs[0] = out0;
    assign irs[1] = ir5;  assign ovs[1] = ov5;  assign outs[1] = {1'b0, out5};
    assign irs[2] = ir1;  assign ovs[2] = ov1;  assign outs[2] = out1;

    int psum [3];
    int pcnt [3];
    int expq [3][64];
    int wr   [3];
    int rd   [3];
    bit hold_p [3];
    int held [3];
    int obs0 [$];
    int obs5 [$];

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                chk("in_ready_during_rst", int'(irs[d]), 0);
                psum[d]   = 0;
                pcnt[d]   = 0;
                rd[d]     = wr[d];
                hold_p[d] = 1'b0;
            end else begin
                if (hold_p[d]) begin
                    chk("held_out_valid", int'(ovs[d]), 1);
                    chk("held_out_stable", int'(outs[d]), held[d]);
                end
                if (in_valid && irs[d]) begin
                    psum[d] += op_res(a, b, m);
                    pcnt[d]++;
                    if (pcnt[d] == LEN[d]) begin
                        expq[d][wr[d] % 64] = grp_res(psum[d], WID[d]);
                        wr[d]++;
                        psum[d] = 0;
                        pcnt[d] = 0;
                    end
                end
                if (ovs[d] && out_ready) begin
                    chk("result_expected", int'(wr[d] > rd[d]), 1);
                    if (wr[d] > rd[d]) begin
                        chk("group_result", int'(outs[d]), expq[d][rd[d] % 64]);
                        rd[d]++;
                    end
                    if (d == 0) obs0.push_back(int'(outs[d]));
                    if (d == 1) obs5.push_back(int'(outs[d]));
                end
                hold_p[d] = ovs[d] && !out_ready;
                held[d]   = int'(outs[d]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [1:0] aa, input logic [1:0] bb, input logic mm);
        a = aa;
        b = bb;
        m = mm;
        in_valid = 1'b1;
        #1;
        for (int n = 0; n < 20; n++) begin
            if (ir0) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            stalls++;
            step();
        end
        chk("beat_accept_timeout", int'(ir0), 1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic       m;
        int         gap;
        int         e6;
        int         e5;
    } vec_t;

    vec_t tbl [6];

    initial begin
        tbl[0] = '{a: 2'd3, b: 2'd3, m: 1'b1, gap: 0, e6: 36, e5: E5_36};
        tbl[1] = '{a: 2'd2, b: 2'd2, m: 1'b1, gap: 3, e6: 16, e5: 16};
        tbl[2] = '{a: 2'd3, b: 2'd3, m: 1'b0, gap: 2, e6: 24, e5: 24};
        tbl[3] = '{a: 2'd2, b: 2'd1, m: 1'b0, gap: 1, e6: 12, e5: 12};
        tbl[4] = '{a: 2'd0, b: 2'd3, m: 1'b1, gap: 3, e6: 0,  e5: 0};
        tbl[5] = '{a: 2'd3, b: 2'd3, m: 1'b1, gap: 3, e6: 36, e5: E5_36};

        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        m = 1'b0;
        out_ready = 1'b1;

        // reset state
        step();
        step();
        chk("rst_in_ready", int'(ir0), 0);
        chk("rst_out_valid", int'(ov0), 0);
        chk("rst_out", int'(out0), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", int'(ir0), 1);
        idle(2);

        // back-to-back 3*3 group: latency and single-cycle out_valid
        obs0.delete();
        obs5.delete();
        for (int i = 0; i < 4; i++) send_beat(2'd3, 2'd3, 1'b1);
        chk("last_accept_edge_out_valid", int'(ov0), 0);
        step();
        chk("group_out_valid", int'(ov0), 1);
        chk("group_out_36", int'(out0), 36);
        chk("group_out_w5", int'(out5), E5_36);
        step();
        chk("out_valid_one_cycle", int'(ov0), 0);
        idle(3);

        // two groups back-to-back: one bubble
        obs0.delete();
        stalls = 0;
        for (int i = 0; i < 4; i++) send_beat(2'd2, 2'd1, 1'b0);
        for (int i = 0; i < 4; i++) send_beat(2'd1, 2'd2, 1'b1);
        idle(6);
        chk("two_groups_count", obs0.size(), 2);
        if (obs0.size() == 2) begin
            chk("two_groups_first", obs0[0], 12);
            chk("two_groups_second", obs0[1], 8);
        end
        chk("hold_bubble_count", stalls, 1);

        // table-driven groups with random idle gaps
        for (int t = 0; t < 6; t++) begin
            obs0.delete();
            obs5.delete();
            for (int i = 0; i < 4; i++) begin
                send_beat(tbl[t].a, tbl[t].b, tbl[t].m);
                idle($urandom_range(0, tbl[t].gap));
            end
            idle(6);
            chk("tbl_count", obs0.size(), 1);
            chk("tbl_count_w5", obs5.size(), 1);
            if (obs0.size() == 1) chk("tbl_out", obs0[0], tbl[t].e6);
            if (obs5.size() == 1) chk("tbl_out_w5", obs5[0], tbl[t].e5);
        end

        // backpressure: result held 5 cycles while in_valid stays high
        obs0.delete();
        out_ready = 1'b0;
        a = 2'd1;
        b = 2'd1;
        m = 1'b1;
        in_valid = 1'b1;
        begin
            int n;
            n = 0;
            while (!ov0 && n < 40) begin
                step();
                n++;
            end
            chk("bp_out_valid_timeout", int'(ov0), 1);
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_held", int'(out0), 4);
            chk("bp_out_valid_held", int'(ov0), 1);
            chk("bp_in_ready_low", int'(ir0), 0);
            step();
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        step();
        chk("bp_release_out_valid", int'(ov0), 0);
        chk("bp_release_in_ready", int'(ir0), 1);
        for (int i = 0; i < 3; i++) send_beat(2'd1, 2'd1, 1'b1);
        idle(6);
        chk("bp_count", obs0.size(), 2);
        if (obs0.size() == 2) begin
            chk("bp_first", obs0[0], 4);
            chk("bp_second", obs0[1], 4);
        end

        // reset mid-group
        obs0.delete();
        obs5.delete();
        send_beat(2'd3, 2'd3, 1'b1);
        send_beat(2'd3, 2'd3, 1'b1);
        in_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_mid_in_ready", int'(ir0), 0);
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("rst_mid_out_valid", int'(ov0), 0);
        for (int i = 0; i < 4; i++) send_beat(2'd1, 2'd1, 1'b0);
        idle(6);
        chk("rst_mid_count", obs0.size(), 1);
        chk("rst_mid_count_w5", obs5.size(), 1);
        if (obs0.size() == 1) chk("rst_mid_out", obs0[0], 8);
        if (obs5.size() == 1) chk("rst_mid_out_w5", obs5[0], 8);

        // randomized traffic against the scoreboard
        for (int c = 0; c < 2500; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = 2'($urandom_range(0, 3));
            b         = 2'($urandom_range(0, 3));
            m         = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) != 0);
            rst       = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        out_ready = 1'b1;
        idle(12);
        for (int d = 0; d < 3; d++) chk("drained_results", rd[d], wr[d]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
